// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: receives a framed byte stream, writes
// big-endian words into instruction memory and holds the core in reset until the checksum matches.
module im_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t            r_state;
    logic [15:0]       r_n;
    logic [ADDR_W-1:0] r_word_idx;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic [7:0]        r_sum;

    logic              w_accept;
    logic [15:0]       w_count;
    logic              w_oversize;
    logic              w_last_word;

    assign in_ready    = rst && (r_state != DONE) && (r_state != ERROR);
    assign w_accept    = in_valid && in_ready;
    assign w_count     = {r_n[15:8], in_data};
    assign w_oversize  = 32'(w_count) > 32'(DEPTH);
    // Word index is compared one-ahead so the write of word N-1 is recognised as the last one.
    assign w_last_word = (32'(r_word_idx) + 32'd1) == 32'(r_n);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= CNT_HI;
            r_n        <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_sum      <= '0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (r_state)
                CNT_HI: begin
                    if (w_accept) begin
                        r_n[15:8] <= in_data;
                        r_state   <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (w_accept) begin
                        r_n[7:0] <= in_data;
                        if (w_oversize) begin
                            r_state <= ERROR;
                            err     <= 1'b1;
                        end else if (w_count == 16'd0) begin
                            r_state <= CHECK;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_sum <= r_sum + in_data;
                        if (r_byte_cnt == 2'd3) begin
                            im_we      <= 1'b1;
                            im_addr    <= r_word_idx;
                            im_wdata   <= {r_asm, in_data};
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                            r_byte_cnt <= 2'd0;
                            if (w_last_word) begin
                                r_state <= CHECK;
                            end
                        end else begin
                            r_asm      <= {r_asm[15:0], in_data};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        if (in_data == r_sum) begin
                            r_state <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= ERROR;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        r_state    <= CNT_HI;
                        r_n        <= '0;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                        r_sum      <= '0;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                default: begin
                    r_state <= CNT_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: good, bad, empty, oversize,
// gapped, reset-interrupted and reload frames.
module tb_im_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int compCnt = 0;
    int failCnt = 0;
    int cycleCnt = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wrQ[$];

    im_loader #(.ADDR_W(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Every cycle with a write strobe is logged, so a stretched strobe shows up as an extra entry.
    always @(negedge clk) begin
        if (im_we) wrQ.push_back('{addr: im_addr, data: im_wdata, cyc: cycleCnt});
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCnt++;
        assert (observed === expected) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input int idx, input logic [9:0] addr, input logic [31:0] data);
        if (idx < wrQ.size()) begin
            checkOutput({tag, ".addr"}, 32'(wrQ[idx].addr), 32'(addr));
            checkOutput({tag, ".data"}, wrQ[idx].data, data);
        end else begin
            compCnt++;
            failCnt++;
            $error("[TB] FAIL %s: write %0d missing, only %0d seen", tag, idx, wrQ.size());
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) begin
            applyStimulus(bytes[i]);
            if (gaps && i != bytes.size() - 1) begin
                repeat ($urandom_range(1, 3)) begin
                    in_data = 8'($urandom);
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [7:0] goodImg[$] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};

    initial begin
        logic [7:0] frame[$];
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst.in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst.im_we", 32'(im_we), 32'd0);
        checkOutput("rst.im_addr", 32'(im_addr), 32'd0);
        checkOutput("rst.im_wdata", im_wdata, 32'd0);
        checkOutput("rst.cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.err", 32'(err), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("rst.ready_rise", 32'(in_ready), 32'd1);

        $display("[TB] good image");
        wrQ.delete();
        sendFrame(goodImg, 1'b0);
        checkOutput("good.cpu_rst_pre", 32'(cpu_rst), 32'd1);
        checkOutput("good.done_pre", 32'(done), 32'd0);
        applyStimulus(8'h60);
        checkOutput("good.done", 32'(done), 32'd1);
        checkOutput("good.cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("good.in_ready", 32'(in_ready), 32'd0);
        checkOutput("good.wrCount", 32'(wrQ.size()), 32'd2);
        checkWrite("good.w0", 0, 10'd0, 32'h20080005);
        checkWrite("good.w1", 1, 10'd1, 32'h2009000A);
        if (wrQ.size() == 2) checkOutput("good.spacing", 32'(wrQ[1].cyc - wrQ[0].cyc), 32'd4);
        checkOutput("good.addr_hold", 32'(im_addr), 32'd1);
        checkOutput("good.wdata_hold", im_wdata, 32'h2009000A);

        $display("[TB] bad checksum");
        pulseStart();
        checkOutput("restart.cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("restart.done", 32'(done), 32'd0);
        checkOutput("restart.in_ready", 32'(in_ready), 32'd1);
        wrQ.delete();
        sendFrame(goodImg, 1'b0);
        applyStimulus(8'h61);
        checkOutput("bad.err", 32'(err), 32'd1);
        checkOutput("bad.cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("bad.in_ready", 32'(in_ready), 32'd0);
        checkOutput("bad.done", 32'(done), 32'd0);
        checkOutput("bad.wrCount", 32'(wrQ.size()), 32'd2);

        $display("[TB] empty image");
        pulseStart();
        checkOutput("restart2.err", 32'(err), 32'd0);
        wrQ.delete();
        frame = '{8'h00, 8'h00, 8'h00};
        sendFrame(frame, 1'b0);
        checkOutput("empty.done", 32'(done), 32'd1);
        checkOutput("empty.cpu_rst", 32'(cpu_rst), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("empty.wrCount", 32'(wrQ.size()), 32'd0);

        $display("[TB] oversize image");
        pulseStart();
        wrQ.delete();
        frame = '{8'h04, 8'h01};
        sendFrame(frame, 1'b0);
        checkOutput("over.err", 32'(err), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        checkOutput("over.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        checkOutput("over.err_hold", 32'(err), 32'd1);
        checkOutput("over.wrCount", 32'(wrQ.size()), 32'd0);

        $display("[TB] full-depth count accepted, partial word dropped by reset");
        pulseStart();
        frame = '{8'h04, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        sendFrame(frame, 1'b0);
        checkOutput("depth.err", 32'(err), 32'd0);
        checkOutput("depth.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("depth.rst_ready", 32'(in_ready), 32'd0);
        checkOutput("depth.cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("depth.wrCount", 32'(wrQ.size()), 32'd0);
        rst = 1'b1;

        $display("[TB] gapped good image");
        wrQ.delete();
        frame = goodImg;
        frame.push_back(8'h60);
        sendFrame(frame, 1'b1);
        checkOutput("gap.done", 32'(done), 32'd1);
        checkOutput("gap.wrCount", 32'(wrQ.size()), 32'd2);
        checkWrite("gap.w0", 0, 10'd0, 32'h20080005);
        checkWrite("gap.w1", 1, 10'd1, 32'h2009000A);

        $display("[TB] reset after byte 6");
        pulseStart();
        wrQ.delete();
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        sendFrame(frame, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst.cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("midrst.wrCount", 32'(wrQ.size()), 32'd1);
        checkWrite("midrst.w0", 0, 10'd0, 32'h20080005);
        rst = 1'b1;
        wrQ.delete();
        frame = goodImg;
        frame.push_back(8'h60);
        sendFrame(frame, 1'b0);
        checkOutput("fresh.done", 32'(done), 32'd1);
        checkOutput("fresh.cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("fresh.wrCount", 32'(wrQ.size()), 32'd2);
        checkWrite("fresh.w1", 1, 10'd1, 32'h2009000A);

        $display("[TB] reload");
        pulseStart();
        checkOutput("reload.cpu_rst", 32'(cpu_rst), 32'd1);
        wrQ.delete();
        frame = '{8'h00, 8'h01, 8'hAB, 8'hCD};
        sendFrame(frame, 1'b0);
        pulseStart();
        checkOutput("reload.start_ignored_ready", 32'(in_ready), 32'd1);
        checkOutput("reload.start_ignored_done", 32'(done), 32'd0);
        frame = '{8'hEF, 8'h01};
        sendFrame(frame, 1'b0);
        checkOutput("reload.done_pre", 32'(done), 32'd0);
        applyStimulus(8'h68);
        checkOutput("reload.done", 32'(done), 32'd1);
        checkOutput("reload.cpu_rst_low", 32'(cpu_rst), 32'd0);
        checkOutput("reload.wrCount", 32'(wrQ.size()), 32'd1);
        checkWrite("reload.w0", 0, 10'd0, 32'hABCDEF01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
